// File: rtl/niosii_system_pulse_out_pio_pkg.sv
// Shared constants for the pulse output PIO: register map and default widths.
// Pure declarations; no latency or flow-control behaviour of its own.
package niosii_system_pulse_out_pio_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int BUS_WIDTH      = 32;
  localparam int ADDR_WIDTH     = 3;

  localparam logic [ADDR_WIDTH-1:0] ADDR_DATA      = 3'd0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_PULSE_LEN = 3'd1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_PULSE     = 3'd2;
  localparam logic [ADDR_WIDTH-1:0] ADDR_OUTSET    = 3'd4;
  localparam logic [ADDR_WIDTH-1:0] ADDR_OUTCLEAR  = 3'd5;

endpackage

// File: rtl/niosii_system_pulse_out_pio_if.sv
// Avalon-MM slave bus bundle for the pulse output PIO.
// No wait-request: the slave is always ready, reads return one cycle after address.
interface niosii_system_pulse_out_pio_if;
  import niosii_system_pulse_out_pio_pkg::*;

  logic [ADDR_WIDTH-1:0] address;
  logic                  chipselect;
  logic                  write_n;
  logic [BUS_WIDTH-1:0]  writedata;
  logic [BUS_WIDTH-1:0]  readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/niosii_system_pulse_out_pio_timer.sv
// One-shot pulse timer: holds the pulsing-bit mask and a down-counter, flags expiry.
// expire is combinational from the counter (asserted while count==1); never stalls.
module niosii_system_pulse_timer
  import niosii_system_pulse_out_pio_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] mask,
  input  logic [CNT_WIDTH-1:0]  len,
  input  logic [DATA_WIDTH-1:0] cancel_mask,
  output logic [DATA_WIDTH-1:0] pulse_mask,
  output logic                  expire
);

  logic [CNT_WIDTH-1:0]  count;
  logic [CNT_WIDTH-1:0]  count_next;
  logic [DATA_WIDTH-1:0] mask_next;

  assign expire = (count == CNT_WIDTH'(1));

  // Expiry clears the old mask first so a coincident start begins a clean, full-length pulse.
  always_comb begin
    count_next = count;
    mask_next  = pulse_mask;
    if (count != '0) begin
      count_next = count - CNT_WIDTH'(1);
    end
    if (expire) begin
      mask_next = '0;
    end
    mask_next = mask_next & ~cancel_mask;
    if (start) begin
      mask_next  = mask_next | mask;
      count_next = len;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      pulse_mask <= '0;
    end else begin
      count      <= count_next;
      pulse_mask <= mask_next;
    end
  end

endmodule

// File: rtl/niosii_system_pulse_out_pio.sv
// Avalon-MM output PIO with atomic set/clear and a hardware one-shot pulse on out_port.
// Write-to-pin 1 cycle, readdata valid 1 cycle after address; always ready, no wait states.
module niosii_system_pulse_out_pio
  import niosii_system_pulse_out_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  niosii_system_pulse_out_pio_if.slave    bus,
  output logic [DATA_WIDTH-1:0]           out_port
);

  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_next;
  logic [CNT_WIDTH-1:0]  pulse_len_q;
  logic [DATA_WIDTH-1:0] wd;
  logic                  wr;
  logic                  wr_data;
  logic                  wr_len;
  logic                  wr_pulse;
  logic                  wr_set;
  logic                  wr_clr;
  logic                  start;
  logic [DATA_WIDTH-1:0] cancel_mask;
  logic [DATA_WIDTH-1:0] pulse_mask;
  logic                  expire;
  logic [BUS_WIDTH-1:0]  rd_mux;
  logic                  unused_writedata;

  assign unused_writedata = ^bus.writedata;

  assign wd       = bus.writedata[DATA_WIDTH-1:0];
  assign wr       = bus.chipselect & ~bus.write_n;
  assign wr_data  = wr && (bus.address == ADDR_DATA);
  assign wr_len   = wr && (bus.address == ADDR_PULSE_LEN);
  assign wr_pulse = wr && (bus.address == ADDR_PULSE);
  assign wr_set   = wr && (bus.address == ADDR_OUTSET);
  assign wr_clr   = wr && (bus.address == ADDR_OUTCLEAR);

  assign start = wr_pulse && (pulse_len_q != '0) && (wd != '0);

  // Bits the CPU explicitly drives low stop being owned by the pulse timer.
  assign cancel_mask = wr_clr  ? wd  :
                       wr_data ? ~wd : '0;

  niosii_system_pulse_timer #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mask        (wd),
    .len         (pulse_len_q),
    .cancel_mask (cancel_mask),
    .pulse_mask  (pulse_mask),
    .expire      (expire)
  );

  // Expiry clear lands first so a coincident CPU write wins on overlapping bits.
  always_comb begin
    data_next = data_q;
    if (expire) begin
      data_next = data_next & ~pulse_mask;
    end
    if (wr_data) begin
      data_next = wd;
    end else if (wr_set) begin
      data_next = data_next | wd;
    end else if (wr_clr) begin
      data_next = data_next & ~wd;
    end else if (start) begin
      data_next = data_next | wd;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA:      rd_mux = BUS_WIDTH'(data_q);
      ADDR_PULSE_LEN: rd_mux = BUS_WIDTH'(pulse_len_q);
      ADDR_PULSE:     rd_mux = BUS_WIDTH'(pulse_mask);
      default:        rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q       <= RESET_VALUE;
      pulse_len_q  <= '0;
      bus.readdata <= '0;
    end else begin
      data_q       <= data_next;
      bus.readdata <= rd_mux;
      if (wr_len) begin
        pulse_len_q <= bus.writedata[CNT_WIDTH-1:0];
      end
    end
  end

  assign out_port = data_q;

endmodule

// File: tb/tb_niosii_system_pulse_out_pio.sv
// Scoreboard bench for the pulse output PIO: stimulus pushes expected pin/readdata, monitor pops.
// Reference model tracks pulses by absolute expiry edge rather than a down-counter.
`timescale 1ns/1ps
module tb_niosii_system_pulse_out_pio;

  localparam logic [7:0] RST_VAL = 8'hA5;

  typedef struct {
    logic [7:0]  out_e;
    logic [31:0] rd_e;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] out_port;

  niosii_system_pulse_out_pio_if bus();

  niosii_system_pulse_out_pio #(
    .DATA_WIDTH  (8),
    .RESET_VALUE (RST_VAL),
    .CNT_WIDTH   (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  logic [7:0]  m_data = RST_VAL;
  logic [15:0] m_len  = '0;
  logic [7:0]  m_mask = '0;
  bit          m_active = 1'b0;
  int          m_expire = 0;
  int          m_edge = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp_v);
    end
  endtask

  task automatic model_reset();
    m_data   = RST_VAL;
    m_len    = '0;
    m_mask   = '0;
    m_active = 1'b0;
  endtask

  // Drive one bus cycle and predict the DUT state right after the following rising edge.
  task automatic cycle(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wdat);
    exp_t       e;
    logic [7:0] wd;
    bit         wr;
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.writedata  = wdat;
    wd = wdat[7:0];
    wr = cs && !wn;
    case (a)
      3'd0:    e.rd_e = 32'(m_data);
      3'd1:    e.rd_e = 32'(m_len);
      3'd2:    e.rd_e = 32'(m_mask);
      default: e.rd_e = 32'd0;
    endcase
    m_edge++;
    if (m_active && m_edge == m_expire) begin
      m_data   = m_data & ~m_mask;
      m_mask   = '0;
      m_active = 1'b0;
    end
    if (wr) begin
      case (a)
        3'd0: begin m_mask = m_mask & wd; m_data = wd; end
        3'd1: m_len = wdat[15:0];
        3'd2: if (m_len != 0 && wd != 0) begin
                m_data   = m_data | wd;
                m_mask   = m_mask | wd;
                m_active = 1'b1;
                m_expire = m_edge + int'(m_len);
              end
        3'd4: m_data = m_data | wd;
        3'd5: begin m_data = m_data & ~wd; m_mask = m_mask & ~wd; end
        default: ;
      endcase
    end
    e.out_e = m_data;
    q.push_back(e);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    cycle(a, 1'b1, 1'b0, d);
  endtask

  task automatic rd_reg(input logic [2:0] a, input int n);
    for (int i = 0; i < n; i++) cycle(a, 1'b1, 1'b1, 32'd0);
  endtask

  // Monitor: every rising edge with a pending prediction is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("out_port", 32'(out_port), 32'(e.out_e));
        chk("readdata", bus.readdata, e.rd_e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  a;
    logic [31:0] d;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    #23;
    chk("reset_out_port", 32'(out_port), 32'(RST_VAL));
    chk("reset_readdata", bus.readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Set/clear, readback, upper bits ignored
    wr_reg(3'd0, 32'h0000_000F);
    wr_reg(3'd4, 32'h0000_0030);
    wr_reg(3'd5, 32'h0000_0003);
    rd_reg(3'd0, 2);
    wr_reg(3'd0, 32'hFFFF_FF00);
    rd_reg(3'd0, 1);

    // Pulse timing
    wr_reg(3'd1, 32'd5);
    wr_reg(3'd2, 32'h0000_0081);
    rd_reg(3'd2, 8);

    // Retrigger
    wr_reg(3'd1, 32'd10);
    wr_reg(3'd2, 32'h0000_0001);
    rd_reg(3'd2, 4);
    wr_reg(3'd2, 32'h0000_0002);
    rd_reg(3'd2, 12);

    // OUTSET coincident with expiry keeps the bit
    wr_reg(3'd1, 32'd3);
    wr_reg(3'd2, 32'h0000_0001);
    rd_reg(3'd2, 2);
    wr_reg(3'd4, 32'h0000_0001);
    rd_reg(3'd0, 3);

    // Zero-length and zero-mask pulse writes are no-ops
    wr_reg(3'd0, 32'h0000_0000);
    wr_reg(3'd1, 32'd0);
    wr_reg(3'd2, 32'h0000_0055);
    rd_reg(3'd2, 3);
    wr_reg(3'd1, 32'd4);
    wr_reg(3'd2, 32'h0000_0100);
    rd_reg(3'd2, 6);

    // Unused addresses
    wr_reg(3'd3, 32'hFFFF_FFFF);
    wr_reg(3'd6, 32'hFFFF_FFFF);
    wr_reg(3'd7, 32'hFFFF_FFFF);
    for (int i = 3; i < 8; i++) rd_reg(3'(i), 1);
    rd_reg(3'd0, 1);

    // Reset mid-pulse is immediate
    wr_reg(3'd0, 32'h0000_00FF);
    wr_reg(3'd1, 32'd20);
    wr_reg(3'd2, 32'h0000_0001);
    rd_reg(3'd0, 2);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_out_port", 32'(out_port), 32'(RST_VAL));
    chk("async_reset_readdata", bus.readdata, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    rd_reg(3'd2, 2);
    rd_reg(3'd1, 1);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd1) d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 12));
      cycle(a, ($urandom % 4) != 0, ($urandom % 2) != 0, d);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/niosii_system_pulse_out_pio.md
Name: niosII_system_pulse_out_pio

Overview:
- Avalon-MM slave output PIO. It drives board-level actuators/LEDs (maze solenoids, status LEDs) from the Nios II.
- It is the write-direction counterpart of the input switch PIOs: the CPU writes registers, and the block drives out_port.
- Adds atomic bit set/clear plus a hardware one-shot pulse timer, so software needs no timed busy-wait to strobe an output.
- Sits on the system interconnect with a 1-cycle registered read path.

Parameters:
DATA_WIDTH, 8, width of out_port and of every data/mask register
RESET_VALUE, 0, value loaded into DATA (and out_port) on reset
CNT_WIDTH, 16, width of the pulse length register and down-counter

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  asynchronous, active-high reset
address  input  3  word register select
chipselect  input  1  slave select, qualifies reads and writes
write_n  input  1  active-low write strobe, valid when chipselect=1
writedata  input  32  write data; upper unused bits ignored
readdata  output  32  registered read data, zero-extended
out_port  output  DATA_WIDTH  registered actuator/LED outputs

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: DATA=RESET_VALUE, out_port=RESET_VALUE, PULSE_LEN=0, pulse_mask=0, counter=0, readdata=0. A reset mid-pulse aborts the pulse immediately.
- Write = chipselect & ~write_n, taking writedata[DATA_WIDTH-1:0] (or [CNT_WIDTH-1:0] for address 1).
- Register map:
  - 0 DATA R/W: a write replaces DATA.
  - 1 PULSE_LEN R/W.
  - 2 PULSE: a write starts a pulse; a read returns the active pulse_mask.
  - 3: reads 0, writes ignored.
  - 4 OUTSET W: DATA |= wd.
  - 5 OUTCLEAR W: DATA &= ~wd.
  - 6, 7: reads 0, writes ignored.
  - Reads of 4 and 5 return 0.
- out_port = DATA, registered. It changes on the clock edge after the write cycle (1-cycle write-to-pin latency).
- Read: readdata is updated every cycle from the mux on address (read mux is not gated by chipselect; same style as the input PIOs), so data is valid one cycle after address. Reads have no side effects.
- Pulse start: write to PULSE with PULSE_LEN!=0 and wd!=0:
  - DATA |= wd.
  - pulse_mask |= wd.
  - counter <= PULSE_LEN.
  - A write with PULSE_LEN=0 or wd=0 is a no-op.
- Pulse run: while counter!=0, counter decrements by 1 each cycle.
  - On the cycle counter==1, expiry: DATA &= ~pulse_mask, pulse_mask <= 0, counter <= 0.
  - Bits are therefore high on out_port for exactly PULSE_LEN cycles.
- Retrigger: a PULSE write while active reloads counter to PULSE_LEN and ORs in the new mask. All masked bits share one expiry.
- Same-cycle priority: the expiry clear is applied first, then the CPU write.
  - A DATA/OUTSET write coincident with expiry wins on overlapping bits.
  - A PULSE write coincident with expiry: old mask bits not in the new mask clear; the new mask starts a fresh full-length pulse.
- Explicit CPU changes during a pulse:
  - OUTCLEAR or a DATA write of 0 on a pulsing bit clears it immediately and also removes it from pulse_mask.
  - A DATA write does not cancel the timer for other bits.
- Writing PULSE_LEN mid-pulse does not affect the running counter, only future pulses.
- No wrap-around: the counter stops at 0.

Decomposition:
- Shared package holds:
  - address constants: ADDR_DATA=0, ADDR_PULSE_LEN=1, ADDR_PULSE=2, ADDR_OUTSET=4, ADDR_OUTCLEAR=5.
  - default widths.
- One natural sub-module: niosII_system_pulse_timer, containing counter, pulse_mask and the expire strobe. Inputs: start, mask, len, cancel_mask.
- Register file and read mux stay in the top module.

Test Plan:
- Reset: assert reset mid-run with DATA=0xFF and a pulse active -> out_port=RESET_VALUE, readdata=0, pulse_mask=0 immediately (asynchronous).
- Set/clear: write DATA=0x0F, OUTSET 0x30, OUTCLEAR 0x03 -> out_port 0x0F, 0x3F, 0x3C, each one cycle after its write. Read address 0 -> 0x0000003C.
- Pulse timing: PULSE_LEN=5, PULSE 0x81 with DATA=0x00 -> out_port=0x81 for exactly 5 cycles, then 0x00. Address 2 reads 0x81 during the pulse, 0x00 after.
- Retrigger: PULSE_LEN=10, PULSE 0x01, then PULSE 0x02 on cycle 6 -> both bits drop together 10 cycles after the second write.
- Coincident events: an OUTSET 0x01 landing on the expiry cycle of pulse 0x01 -> bit 0 stays 1. A PULSE_LEN=0 pulse write -> no change.
- Unused/zero-length cases: writes to addresses 3, 6, 7 -> no state change, reads 0. Reads of addresses 4/5 -> 0. Upper writedata bits [31:DATA_WIDTH] never appear on out_port.
